// File: rtl/spi_flash_xip_slave_pkg.sv
// Shared definitions for the SPI flash execute-in-place read slave.
// Holds the transfer FSM state type, the READ opcode and the field widths
// of a READ transaction (command byte, 24-bit byte address, 32-bit word).
package spi_flash_xip_slave_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CMD    = 3'd1,
      ADDR   = 3'd2,
      DATA   = 3'd3,
      IGNORE = 3'd4
   } state_t;

   localparam logic [7:0] READ_OPCODE = 8'h03;
   localparam int         CMD_BITS    = 8;
   localparam int         ADDR_BITS   = 24;
   localparam int         WORD_BITS   = 32;

endpackage

// File: rtl/spi_flash_xip_slave_if.sv
// Bus bundle between an SPI master, the flash slave and its backing memory.
// Signals:
//   spi_sck    SPI serial clock (idles low, asynchronous to the system clock)
//   spi_ss     active-low chip selects, SS_NUM wide
//   spi_mosi   command/address bits from the master
//   spi_miso   read-data bits to the master
//   mem_ren    one-cycle read strobe to the word memory
//   mem_raddr  word address (byte address bits [23:2])
//   mem_rdata  little-endian read word, valid one cycle after mem_ren
// Modports: slave (the flash slave), master (SPI master + memory model).
interface spi_flash_xip_slave_if
   import spi_flash_xip_slave_pkg::*;
#(
   parameter int SS_NUM = 8
);
   logic                     spi_sck;
   logic [SS_NUM-1:0]        spi_ss;
   logic                     spi_mosi;
   logic                     spi_miso;
   logic                     mem_ren;
   logic [ADDR_BITS-3:0]     mem_raddr;
   logic [WORD_BITS-1:0]     mem_rdata;

   modport slave (
      input  spi_sck, spi_ss, spi_mosi, mem_rdata,
      output spi_miso, mem_ren, mem_raddr
   );

   modport master (
      output spi_sck, spi_ss, spi_mosi, mem_rdata,
      input  spi_miso, mem_ren, mem_raddr
   );
endinterface

// File: rtl/spi_flash_xip_slave_edge_sync.sv
// Two-flop synchroniser with rising/falling edge detection.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   din           asynchronous input level
//   rise, fall    one-cycle pulses when the synchronised level changes
module spi_edge_sync (
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic rise,
   output logic fall
);
   logic sync_p0;
   logic sync_p1;
   logic dly_p2;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         dly_p2  <= 1'b0;
      end else begin
         sync_p0 <= din;
         sync_p1 <= sync_p0;
         dly_p2  <= sync_p1;
      end
   end

   assign rise = sync_p1 & ~dly_p2;
   assign fall = ~sync_p1 & dly_p2;
endmodule

// File: rtl/spi_flash_xip_slave.sv
// SPI flash READ (0x03) slave that serves data from a word-wide memory,
// streaming consecutive words for as long as chip select stays low.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   bus           slave modport: SPI pins plus memory read port
// Parameters:
//   SS_NUM        width of the chip-select bus
//   SS_SEL        index of the chip-select bit for this flash
module spi_flash_xip_slave
   import spi_flash_xip_slave_pkg::*;
#(
   parameter int SS_NUM = 8,
   parameter int SS_SEL = 0
) (
   input  logic                    clock,
   input  logic                    reset,
   spi_flash_xip_slave_if.slave    bus
);
   logic                 sck_rise;
   logic                 sck_fall;
   logic                 ss_p0;
   logic                 ss_p1;
   logic                 mosi_p0;
   logic                 mosi_p1;
   logic                 armed;
   state_t               state;
   state_t               state_next;
   logic [4:0]           bit_cnt;
   logic [CMD_BITS-2:0]  cmd_sr;
   logic [ADDR_BITS-2:0] addr_sr;
   logic [WORD_BITS-1:0] data_word;
   logic                 ren_q;
   logic                 ren_d;
   logic [ADDR_BITS-3:0] raddr_q;
   logic                 miso_q;
   logic [CMD_BITS-1:0]  cmd_full;
   logic [ADDR_BITS-1:0] addr_full;
   logic                 ss_off;
   logic [SS_NUM-1:0]    unused_ss_bits;

   assign unused_ss_bits = bus.spi_ss;

   spi_edge_sync u_sck_sync (
      .clock (clock),
      .reset (reset),
      .din   (bus.spi_sck),
      .rise  (sck_rise),
      .fall  (sck_fall)
   );

   // ss and mosi synchronisers: same depth as the sck path, so mosi_p1
   // is aligned with the detected sck rise
   always_ff @(posedge clock) begin
      if (reset) begin
         ss_p0   <= 1'b0;
         ss_p1   <= 1'b0;
         mosi_p0 <= 1'b0;
         mosi_p1 <= 1'b0;
      end else begin
         ss_p0   <= bus.spi_ss[SS_SEL];
         ss_p1   <= ss_p0;
         mosi_p0 <= bus.spi_mosi;
         mosi_p1 <= mosi_p0;
      end
   end

   assign ss_off    = ss_p1;
   assign cmd_full  = {cmd_sr, mosi_p1};
   assign addr_full = {addr_sr, mosi_p1};

   // The synchronised ss reads low straight out of reset, so a transfer
   // may only start once ss has been seen high since the last reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         armed <= 1'b0;
      end else if (ss_off) begin
         armed <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (armed) begin
               state_next = CMD;
            end
         end
         CMD: begin
            if (sck_rise && bit_cnt == 5'(CMD_BITS - 1)) begin
               state_next = (cmd_full == READ_OPCODE) ? ADDR : IGNORE;
            end
         end
         ADDR: begin
            if (sck_rise && bit_cnt == 5'(ADDR_BITS - 1)) begin
               state_next = DATA;
            end
         end
         default: begin
         end
      endcase
      // deselect wins over everything, including a coincident sck rise
      if (ss_off) begin
         state_next = IDLE;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         bit_cnt   <= '0;
         cmd_sr    <= '0;
         addr_sr   <= '0;
         data_word <= '0;
         ren_q     <= 1'b0;
         ren_d     <= 1'b0;
         raddr_q   <= '0;
         miso_q    <= 1'b0;
      end else begin
         ren_q <= 1'b0;
         ren_d <= ren_q;
         if (ren_d) begin
            data_word <= bus.mem_rdata;
         end
         if (ss_off || state == IDLE) begin
            bit_cnt <= '0;
            miso_q  <= 1'b0;
         end else begin
            case (state)
               CMD: begin
                  miso_q <= 1'b0;
                  if (sck_rise) begin
                     cmd_sr  <= cmd_full[CMD_BITS-2:0];
                     bit_cnt <= (bit_cnt == 5'(CMD_BITS - 1)) ? 5'd0 : bit_cnt + 5'd1;
                  end
               end
               ADDR: begin
                  miso_q <= 1'b0;
                  if (sck_rise) begin
                     addr_sr <= addr_full[ADDR_BITS-2:0];
                     if (bit_cnt == 5'(ADDR_BITS - 1)) begin
                        ren_q   <= 1'b1;
                        raddr_q <= addr_full[ADDR_BITS-1:2];
                        // bit position within the word of the first byte
                        bit_cnt <= {addr_full[1:0], 3'b000};
                     end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                     end
                  end
               end
               DATA: begin
                  if (sck_rise) begin
                     bit_cnt <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'(WORD_BITS - 1)) begin
                        ren_q   <= 1'b1;
                        raddr_q <= raddr_q + 1'b1;
                     end
                  end
                  // byte bit_cnt[4:3], bit 7 - bit_cnt[2:0] of the word
                  if (sck_fall) begin
                     miso_q <= data_word[{bit_cnt[4:3], ~bit_cnt[2:0]}];
                  end
               end
               default: begin
                  miso_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.spi_miso  = miso_q;
   assign bus.mem_ren   = ren_q;
   assign bus.mem_raddr = raddr_q;
endmodule

// File: tb/tb_spi_flash_xip_slave.sv
module tb_spi_flash_xip_slave;
   import spi_flash_xip_slave_pkg::*;

   localparam int HALF = 5;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail = 0;

   logic [21:0] exp_raddr_q[$];
   logic [31:0] pend_word = '0;
   logic        pend_vld = 1'b0;

   always #5 clock = ~clock;

   spi_flash_xip_slave_if #(.SS_NUM(8)) bus ();

   spi_flash_xip_slave #(.SS_NUM(8), .SS_SEL(0)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [31:0] mem_word(input logic [21:0] a);
      if (a == 22'd1) return 32'h44332211;
      return {~a[7:0], a[15:8] ^ 8'h5A, 2'b10, a[21:16], a[7:0] + 8'h3C};
   endfunction

   // memory model: data is present only in the cycle after mem_ren
   always @(negedge clock) begin
      bus.mem_rdata = pend_vld ? pend_word : 32'hDEADBEEF;
      pend_vld = 1'b0;
      if (bus.mem_ren === 1'b1) begin
         pend_word = mem_word(bus.mem_raddr);
         pend_vld  = 1'b1;
         n_tests++;
         if (exp_raddr_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_mem_ren: got raddr %h, required no mem_ren", bus.mem_raddr);
         end else begin
            logic [21:0] e;
            e = exp_raddr_q.pop_front();
            if (bus.mem_raddr !== e) begin
               n_fail++;
               $display("FAIL mem_raddr: got %h, required %h", bus.mem_raddr, e);
            end
         end
      end
   end

   task automatic sck_bit(input logic mosi_b, output logic miso_b);
      bus.spi_mosi = mosi_b;
      repeat (HALF) @(negedge clock);
      miso_b = bus.spi_miso;
      bus.spi_sck = 1'b1;
      repeat (HALF) @(negedge clock);
      bus.spi_sck = 1'b0;
   endtask

   task automatic send_bits(input logic [31:0] v, input int n);
      logic m;
      for (int i = n - 1; i >= 0; i--) sck_bit(v[i], m);
   endtask

   task automatic recv_byte(output logic [7:0] b);
      logic m;
      b = '0;
      for (int i = 0; i < 8; i++) begin
         sck_bit(1'b0, m);
         b = {b[6:0], m};
      end
   endtask

   task automatic start_xfer();
      bus.spi_ss = 8'hFE;
      repeat (HALF) @(negedge clock);
   endtask

   task automatic end_xfer();
      repeat (HALF) @(negedge clock);
      bus.spi_ss = 8'hFF;
      repeat (4 * HALF) @(negedge clock);
   endtask

   task automatic check_raddr_drained(input string name);
      n_tests++;
      if (exp_raddr_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_missing_mem_ren: got %0d outstanding, required 0", name, exp_raddr_q.size());
         exp_raddr_q.delete();
      end
   endtask

   task automatic do_read(input string name, input logic [23:0] addr, input int nbytes);
      logic [21:0] w;
      logic [31:0] word;
      logic [7:0]  got;
      logic [7:0]  exp_b;
      logic [7:0]  exp_byte_q[$];
      int p;
      w = addr[23:2];
      exp_raddr_q.push_back(w);
      for (int j = 0; j < nbytes; j++) begin
         p = int'(addr[1:0]) + j;
         word = mem_word(w + 22'(p / 4));
         exp_byte_q.push_back(word[8 * (p % 4) +: 8]);
         if (p % 4 == 3) exp_raddr_q.push_back(w + 22'(p / 4 + 1));
      end
      start_xfer();
      send_bits({24'd0, READ_OPCODE}, 8);
      send_bits({8'd0, addr}, 24);
      for (int j = 0; j < nbytes; j++) begin
         recv_byte(got);
         exp_b = exp_byte_q.pop_front();
         n_tests++;
         if (got !== exp_b) begin
            n_fail++;
            $display("FAIL %s_byte%0d: got %h, required %h", name, j, got, exp_b);
         end
      end
      end_xfer();
      check_raddr_drained(name);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      n_tests += 4;
      if (bus.spi_miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b, required 0", bus.spi_miso); end
      if (bus.mem_ren !== 1'b0) begin n_fail++; $display("FAIL reset_mem_ren: got %b, required 0", bus.mem_ren); end
      if (bus.mem_raddr !== 22'd0) begin n_fail++; $display("FAIL reset_mem_raddr: got %h, required 0", bus.mem_raddr); end
      if (dut.state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d, required %0d", dut.state, IDLE); end
      reset = 1'b0;
      repeat (5) @(negedge clock);
   endtask

   task automatic test_read_aligned();
      do_read("aligned", 24'h000004, 4);
   endtask

   task automatic test_back_to_back();
      do_read("stream", 24'h000000, 8);
      do_read("unaligned", 24'h000006, 3);
   endtask

   task automatic test_wrap();
      do_read("wrap", 24'hFFFFFC, 8);
   endtask

   task automatic test_ignore();
      logic m;
      start_xfer();
      for (int i = 0; i < 64; i++) begin
         sck_bit(i < 8 ? (((8'h9F >> (7 - i)) & 8'h01) != 0) : 1'b1, m);
         n_tests++;
         if (m !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_miso_bit%0d: got %b, required 0", i, m);
         end
      end
      n_tests++;
      if (dut.state !== IGNORE) begin
         n_fail++;
         $display("FAIL ignore_state: got %0d, required %0d", dut.state, IGNORE);
      end
      end_xfer();
      check_raddr_drained("ignore");
   endtask

   task automatic test_abort();
      start_xfer();
      send_bits({24'd0, READ_OPCODE}, 8);
      send_bits(32'h00000ABC, 12);
      bus.spi_ss = 8'hFF;
      repeat (3) @(posedge clock);
      #1;
      n_tests++;
      if (dut.state !== IDLE) begin
         n_fail++;
         $display("FAIL abort_state: got %0d, required %0d", dut.state, IDLE);
      end
      repeat (4 * HALF) @(negedge clock);
      check_raddr_drained("abort");
      do_read("after_abort", 24'h000004, 4);
   endtask

   task automatic test_reset_mid_data();
      logic [7:0]  got;
      logic [31:0] word;
      logic m;
      word = mem_word(22'd2);
      exp_raddr_q.push_back(22'd2);
      start_xfer();
      send_bits({24'd0, READ_OPCODE}, 8);
      send_bits(32'h00000008, 24);
      recv_byte(got);
      n_tests++;
      if (got !== word[7:0]) begin
         n_fail++;
         $display("FAIL middata_byte0: got %h, required %h", got, word[7:0]);
      end
      sck_bit(1'b0, m);
      sck_bit(1'b0, m);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      n_tests += 2;
      if (bus.spi_miso !== 1'b0) begin n_fail++; $display("FAIL middata_reset_miso: got %b, required 0", bus.spi_miso); end
      if (dut.state !== IDLE) begin n_fail++; $display("FAIL middata_reset_state: got %0d, required %0d", dut.state, IDLE); end
      // ss still low: the slave must stay silent
      send_bits({24'd0, READ_OPCODE}, 8);
      for (int i = 0; i < 16; i++) begin
         sck_bit(1'b0, m);
         n_tests++;
         if (m !== 1'b0) begin
            n_fail++;
            $display("FAIL middata_silent_bit%0d: got %b, required 0", i, m);
         end
      end
      n_tests++;
      if (dut.state !== IDLE) begin
         n_fail++;
         $display("FAIL middata_still_idle: got %0d, required %0d", dut.state, IDLE);
      end
      end_xfer();
      check_raddr_drained("middata");
      do_read("after_reset", 24'h000004, 4);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.spi_sck  = 1'b0;
      bus.spi_ss   = 8'hFF;
      bus.spi_mosi = 1'b0;
      test_reset();
      test_read_aligned();
      test_back_to_back();
      test_wrap();
      test_ignore();
      test_abort();
      test_reset_mid_data();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/spi_flash_xip_slave.md
SPI_FLASH_XIP_SLAVE -- requirements
Module: spi_flash_xip_slave

Interface
REQ-001 SHALL have parameter SS_NUM, default 8, the width of the chip-select bus from the SPI master.
REQ-002 SHALL have parameter SS_SEL, default 0, the index of the spi_ss bit that selects this flash.
REQ-003 SHALL have the following ports. Clock is `clock`. Reset is `reset`, synchronous and active-high.
- clock  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- spi_sck  in  1  SPI serial clock from the master; idles low; asynchronous to `clock`.
- spi_ss  in  SS_NUM  active-low chip selects; bit SS_SEL is used.
- spi_mosi  in  1  command/address bits from the master.
- spi_miso  out  1  read-data bits to the master.
- mem_ren  out  1  one-cycle read strobe to the backing word memory.
- mem_raddr  out  22  word address, byte address bits [23:2].
- mem_rdata  in  32  little-endian word; valid exactly 1 cycle after mem_ren.

Function
REQ-004 SHALL pass spi_sck, the selected spi_ss bit and spi_mosi through 2-flop synchronisers, then detect sck rise and fall from the synchronised value and its 1-cycle-delayed copy.
REQ-005 SHALL operate correctly for an SCK half-period of at least 4 clock cycles.
REQ-006 SHALL sample mosi on each detected sck rise and update miso on each detected sck fall (mode 0: master shifts out on fall, samples on rise).
REQ-007 SHALL implement a 5-state FSM with states IDLE, CMD, ADDR, DATA and IGNORE.
REQ-008 IDLE: miso=0, bit counter cleared; go to CMD when the synchronised ss is low.
REQ-009 CMD: shift 8 bits MSB first; on the 8th rise go to ADDR if the byte is 0x03, otherwise go to IGNORE.
REQ-010 ADDR: shift 24 address bits MSB first; on the 24th rise assert mem_ren for 1 cycle with mem_raddr=addr[23:2], then go to DATA.
REQ-011 DATA: start at byte addr[1:0] of the fetched word; output each byte MSB first; byte k of a word is mem_rdata[8k+7:8k].
REQ-012 DATA: the first data bit SHALL be on miso after the first sck fall following the 24th address rise.
REQ-013 DATA: on the rise that samples the last bit of byte 3, pulse mem_ren with the next word address; mem_raddr wraps from 0x3FFFFF to 0x000000.
REQ-014 DATA SHALL stream indefinitely until ss deasserts.
REQ-015 IGNORE: miso=0, mem_ren never asserted.
REQ-016 ss high in any state SHALL force IDLE on the next cycle and abort any partial command or address; no mem_ren is issued by a partial transfer.
REQ-017 Sck edges seen while ss is high SHALL be ignored.
REQ-018 If ss deasserts in the same cycle as a sck rise, ss deassertion SHALL take priority.
REQ-019 The bit counter SHALL be 5 bits and wrap modulo 32 in DATA.
REQ-020 The data shift register SHALL load 1 cycle after mem_ren.

Reset
REQ-021 While reset is high: state=IDLE; miso, mem_ren, mem_raddr, counters, shift registers and synchroniser flops = 0.
REQ-022 Reset asserted mid-transfer SHALL abort the transfer.
REQ-023 After reset releases, a new transfer SHALL begin only on a fresh ss falling edge; a low ss at release SHALL wait for ss high before re-arming.

Structure
REQ-024 A shared package SHALL hold the FSM state enum, the READ opcode 0x03, and the widths CMD_BITS=8, ADDR_BITS=24, WORD_BITS=32.
REQ-025 One sub-module spi_edge_sync SHALL contain the 2-flop synchroniser plus rise/fall detector, instantiated for sck; ss and mosi use plain synchronisers.

Verification
REQ-026 Read aligned word: memory word 1 = 0x44332211; send 0x03, address 0x000004, then 32 clocks. Required: exactly one mem_ren with mem_raddr=1; miso bytes 0x11,0x22,0x33,0x44, each MSB first.
REQ-027 Streaming across a word boundary: 64 data clocks from address 0x000000. Required: mem_ren with mem_raddr=0, then 1; words 0 and 1 output back-to-back with no gap bit.
REQ-028 Address wrap: address 0xFFFFFC, 64 data clocks. Required: mem_raddr=0x3FFFFF, then 0x000000.
REQ-029 Unsupported command and abort: command 0x9F followed by 56 clocks. Required: miso=0 throughout and no mem_ren. Separately, ss raised after 12 address bits: no mem_ren, IDLE within 3 cycles.
REQ-030 Reset mid-DATA: assert reset at data bit 10 while ss stays low. Required: miso=0 and IDLE; no response until ss goes high then low again, after which a full 0x03 read returns correct data.
